// File: rtl/timer_dev.sv
// Bus-mapped down-counter timer with one-shot and auto-reload modes.
// Registers: CTRL (enable, mode, interrupt mask), PRESET, and read-only COUNT.
module timer_dev #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:2]        Addr,
    input  logic              WE,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] preset;
    logic [DATA_W-1:0] count;
    logic              irq_flag;

    logic enable;
    logic auto_reload;
    logic wr_ctrl;
    logic wr_preset;

    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign wr_ctrl     = WE && (Addr == 2'b00);
    assign wr_preset   = WE && (Addr == 2'b01);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = LOAD;
            LOAD: state_next = CNT;
            CNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (count <= ONE) begin
                    state_next = INT;
                end
            end
            INT: state_next = auto_reload ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file; bus writes come last so they override same-edge FSM updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl     <= 4'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    count    <= preset;
                    irq_flag <= 1'b0;
                end
                CNT: begin
                    if (enable) begin
                        count <= (count > ONE) ? (count - ONE) : '0;
                    end
                end
                INT: begin
                    irq_flag <= 1'b1;
                    if (!auto_reload) begin
                        ctrl[0] <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (wr_ctrl) begin
                ctrl     <= DIN[3:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= DIN;
                irq_flag <= 1'b0;
            end
        end
    end

    // Auto-reload pulses clear in LOAD; one-shot flags persist until a register write.
    always_comb begin
        DOUT = '0;
        case (Addr)
            2'b00:   DOUT = {{(DATA_W-4){1'b0}}, ctrl};
            2'b01:   DOUT = preset;
            2'b10:   DOUT = count;
            default: DOUT = '0;
        endcase
        IRQ = ctrl[3] & irq_flag;
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev: one-shot, auto-reload, disable, mask,
// reset and bus-write-versus-FSM collision scenarios.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [3:2]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    int total;
    int bad;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus write that lands on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        WE   = 1'b1;
        DIN  = d;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        DIN  = 32'h0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            Addr = a[1:0];
            #1;
            total++;
            if (DOUT !== 32'h0) begin bad++; $display("FAIL reset_dout addr=%0d got=%h exp=%h", a, DOUT, 32'h0); end
        end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    endtask

    task automatic test_one_shot;
        logic [31:0] exp_cnt;
        do_reset();
        wr(2'b10, 32'h1234);
        wr(2'b11, 32'h5678);
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL count_readonly got=%h exp=%h", DOUT, 32'h0); end
        Addr = 2'b11; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL reserved_read got=%h exp=%h", DOUT, 32'h0); end
        wr(2'b01, 32'd5);
        wr(2'b00, 32'h9);              // E0
        tick(2);                       // after E2
        Addr = 2'b10; #1;
        exp_cnt = 32'd5;
        for (int e = 2; e <= 7; e++) begin
            total++;
            if (DOUT !== exp_cnt) begin bad++; $display("FAIL oneshot_count E%0d got=%0d exp=%0d", e, DOUT, exp_cnt); end
            total++;
            if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early E%0d got=%b exp=0", e, IRQ); end
            if (e < 7) begin
                tick(1);
                exp_cnt = exp_cnt - 32'd1;
            end
        end
        tick(1);                       // after E8
        total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_E8 got=%b exp=1", IRQ); end
        Addr = 2'b00; #1;
        total++;
        if (DOUT !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=%h", DOUT, 32'h8); end
        tick(3);
        total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_held got=%b exp=1", IRQ); end
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL oneshot_count_held got=%h exp=%h", DOUT, 32'h0); end
        wr(2'b00, 32'h8);
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_cleared got=%b exp=0", IRQ); end
    endtask

    task automatic test_auto_reload;
        logic exp_irq;
        do_reset();
        wr(2'b01, 32'd5);
        wr(2'b00, 32'hB);              // E0
        for (int e = 1; e <= 17; e++) begin
            tick(1);
            exp_irq = (e == 8) || (e == 15);
            total++;
            if (IRQ !== exp_irq) begin bad++; $display("FAIL auto_irq E%0d got=%b exp=%b", e, IRQ, exp_irq); end
        end
        Addr = 2'b00; #1;
        total++;
        if (DOUT !== 32'hB) begin bad++; $display("FAIL auto_ctrl got=%h exp=%h", DOUT, 32'hB); end
    endtask

    task automatic test_disable_mid;
        do_reset();
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h9);              // E0
        tick(3);                       // after E3
        wr(2'b00, 32'h0);              // E4
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'd8) begin bad++; $display("FAIL disable_count_E4 got=%0d exp=8", DOUT); end
        tick(6);
        total++;
        if (DOUT !== 32'd8) begin bad++; $display("FAIL disable_count_held got=%0d exp=8", DOUT); end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL disable_irq got=%b exp=0", IRQ); end
    endtask

    task automatic test_mask_preset0;
        do_reset();
        wr(2'b01, 32'd0);
        wr(2'b00, 32'h1);              // E0
        tick(3);                       // after E3, in INT
        Addr = 2'b00; #1;
        total++;
        if (DOUT !== 32'h1) begin bad++; $display("FAIL mask_ctrl_E3 got=%h exp=%h", DOUT, 32'h1); end
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL mask_count_nowrap got=%h exp=%h", DOUT, 32'h0); end
        tick(1);                       // after E4, one-shot INT cleared Enable
        Addr = 2'b00; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL mask_ctrl_E4 got=%h exp=%h", DOUT, 32'h0); end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq_masked got=%b exp=0", IRQ); end
        wr(2'b00, 32'h8);
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq_after_im got=%b exp=0", IRQ); end
        tick(2);
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq_stays got=%b exp=0", IRQ); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h9);              // E0
        tick(9);                       // after E9
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'd3) begin bad++; $display("FAIL rstmid_count_pre got=%0d exp=3", DOUT); end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            Addr = a[1:0];
            #1;
            total++;
            if (DOUT !== 32'h0) begin bad++; $display("FAIL rstmid_dout addr=%0d got=%h exp=%h", a, DOUT, 32'h0); end
        end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%b exp=0", IRQ); end
        tick(3);
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL rstmid_count_idle got=%h exp=%h", DOUT, 32'h0); end
    endtask

    task automatic test_collision;
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h9);              // E0
        tick(4);                       // after E4, state INT
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'h0) begin bad++; $display("FAIL coll_count_E4 got=%h exp=%h", DOUT, 32'h0); end
        wr(2'b00, 32'h9);              // E5 collides with INT clearing Enable
        Addr = 2'b00; #1;
        total++;
        if (DOUT !== 32'h9) begin bad++; $display("FAIL coll_ctrl got=%h exp=%h", DOUT, 32'h9); end
        tick(2);                       // after E7: IDLE->LOAD->count loaded
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'd2) begin bad++; $display("FAIL coll_rearm_count got=%0d exp=2", DOUT); end
        tick(3);                       // after E10
        total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b exp=1", IRQ); end
    endtask

    task automatic test_preset_midcount;
        do_reset();
        wr(2'b01, 32'd4);
        wr(2'b00, 32'h3);              // E0, auto-reload
        tick(2);                       // after E2, count=4
        wr(2'b01, 32'd7);              // E3, count=3
        Addr = 2'b10; #1;
        total++;
        if (DOUT !== 32'd3) begin bad++; $display("FAIL preset_mid_count got=%0d exp=3", DOUT); end
        tick(4);                       // E4:2 E5:1 E6:0/INT E7:LOAD
        tick(1);                       // after E8, count loaded from new PRESET
        total++;
        if (DOUT !== 32'd7) begin bad++; $display("FAIL preset_mid_reload got=%0d exp=7", DOUT); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        Addr  = 2'b00;
        WE    = 1'b0;
        DIN   = 32'h0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_disable_mid();
        test_mask_preset0();
        test_reset_mid();
        test_collision();
        test_preset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-003 SHALL have port Addr, input, 2 bits [3:2]: register select from the bridge (00 CTRL, 01 PRESET, 10 COUNT, 11 reserved).
REQ-004 SHALL have port WE, input, 1 bit: write strobe from the bridge, already gated against CPU exception/interrupt.
REQ-005 SHALL have port DIN, input, 32 bits: write data (CPU PrWD).
REQ-006 SHALL have port DOUT, output, 32 bits: read data toward CPU PrRD.
REQ-007 SHALL have port IRQ, output, 1 bit: interrupt request, wired to one CPU HWInt bit.

Function
REQ-008 SHALL hold CTRL[3:0]: bit0 Enable, bits2:1 Mode (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM (interrupt mask).
REQ-009 SHALL hold 32-bit PRESET and 32-bit COUNT; COUNT is read-only.
REQ-010 SHALL drive DOUT combinationally: Addr 00 -> {28'b0,CTRL}; 01 -> PRESET; 10 -> COUNT; 11 -> 0.
REQ-011 SHALL on WE=1 write DIN[3:0] to CTRL (Addr 00) or DIN to PRESET (Addr 01); writes to Addr 10/11 ignored.
REQ-012 SHALL give a bus write priority over any same-cycle FSM update of the same register.
REQ-013 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-014 IDLE: Enable=1 -> LOAD; else stay; COUNT held.
REQ-015 LOAD: COUNT <= PRESET; -> CNT.
REQ-016 CNT: Enable=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; else (COUNT<=1) COUNT <= 0, -> INT.
REQ-017 INT, Mode 01: irq_flag <= 1, -> LOAD; irq_flag cleared at the following edge (exactly one-cycle pulse); Enable kept.
REQ-018 INT, Mode 00: irq_flag <= 1, CTRL.Enable <= 0, -> IDLE; irq_flag held until a write to CTRL or PRESET, or reset.
REQ-019 SHALL drive IRQ = CTRL.IM & irq_flag, combinationally from registers; IM=0 masks but does not clear irq_flag.
REQ-020 Timing: Enable write at edge E0 -> LOAD at E1 -> COUNT=PRESET at E2 -> INT at E2+max(PRESET,1) -> IRQ high after the next edge.
REQ-021 PRESET=0 SHALL behave as PRESET=1 (no wrap to 0xFFFFFFFF).
REQ-022 Auto-reload period SHALL be max(PRESET,1)+2 cycles; PRESET written mid-count takes effect at the next LOAD.
REQ-023 Enable cleared while in INT, Mode 01: FSM still goes to LOAD, then LOAD -> CNT -> IDLE on the Enable=0 check.

Reset
REQ-024 SHALL on reset==0 at a rising edge set CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE; IRQ=0 and DOUT reflects zeroed registers from that edge.
REQ-025 SHALL let reset override any simultaneous bus write or FSM transition, including mid-count and during INT.

Verification
REQ-026 One-shot: PRESET=5, CTRL=0x9 at E0 -> COUNT 5,4,3,2,1,0 at E2..E7; IRQ=1 after E8; CTRL reads 0x8; IRQ stays high until CTRL written.
REQ-027 Auto-reload: PRESET=5, CTRL=0xB -> one-cycle IRQ pulses after E8 and E15 (period 7); CTRL stays 0xB.
REQ-028 Disable mid-count: PRESET=10, enable at E0, write CTRL=0 at E4 -> COUNT=8 after E4, IDLE at E5, COUNT stays 8, no IRQ.
REQ-029 Mask/PRESET=0: PRESET=0, CTRL=0x1 -> INT at E3, irq_flag set, IRQ=0; write CTRL=0x8 -> IRQ stays 0 (flag cleared by write).
REQ-030 Reset mid-count: reset=0 while COUNT=3 in CNT -> next edge all registers 0, IRQ=0, DOUT=0 for every Addr.
REQ-031 Write-vs-FSM collision: write CTRL=0x9 on the same edge Mode-00 INT clears Enable -> CTRL=0x9 after the edge, timer re-arms via IDLE->LOAD.
